// File: rtl/axi_master_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// axi_master_ctrl_pkg
//   Shared widths, AXI encodings and the sequencer state type used by the
//   inf_Master interface and by axi_burst_master_ctrl.
//   Contents:
//     AXI_*_BITS    field widths of the master port
//     BURST_INCR    AxBURST encoding for incrementing bursts
//     RESP_OKAY     xRESP encoding for a normal completion
//     ctrl_state_t  sequencer states (IDLE, AR, R, AW, W, B)
//     sat_inc       saturating increment for the beat counter
// ---------------------------------------------------------------------------
package axi_master_ctrl_pkg;

  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXI_DATA_BITS  = 32;
  localparam int AXI_STRB_BITS  = AXI_DATA_BITS / 8;
  localparam int AXI_LEN_BITS   = 4;
  localparam int AXI_ID_BITS    = 4;
  localparam int AXI_SIZE_BITS  = 3;
  localparam int AXI_BURST_BITS = 2;
  localparam int AXI_RESP_BITS  = 2;

  localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } ctrl_state_t;

  localparam logic [AXI_LEN_BITS-1:0] LEN_ONE = 1;

  // Counts up but sticks at all-ones so an over-long read burst cannot wrap
  // back around and accidentally match the requested length again.
  function automatic logic [AXI_LEN_BITS-1:0] sat_inc(input logic [AXI_LEN_BITS-1:0] v);
    return (v == '1) ? v : v + LEN_ONE;
  endfunction

endpackage

// File: rtl/inf_Master.sv
// ---------------------------------------------------------------------------
// inf_Master
//   One AXI4 master port (AW, W, B, AR, R channels).
//   Modports:
//     M2AXIout  everything the master drives (addresses, write data, readies)
//     M2AXIin   everything the slave drives (address readies, read data,
//               write response)
// ---------------------------------------------------------------------------
interface inf_Master;
  import axi_master_ctrl_pkg::*;

  // Write address channel
  logic [AXI_ID_BITS-1:0]    awid;
  logic [AXI_ADDR_BITS-1:0]  awaddr;
  logic [AXI_LEN_BITS-1:0]   awlen;
  logic [AXI_SIZE_BITS-1:0]  awsize;
  logic [AXI_BURST_BITS-1:0] awburst;
  logic                      awvalid;
  logic                      awready;
  // Write data channel
  logic [AXI_DATA_BITS-1:0]  wdata;
  logic [AXI_STRB_BITS-1:0]  wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;
  // Write response channel
  logic [AXI_ID_BITS-1:0]    bid;
  logic [AXI_RESP_BITS-1:0]  bresp;
  logic                      bvalid;
  logic                      bready;
  // Read address channel
  logic [AXI_ID_BITS-1:0]    arid;
  logic [AXI_ADDR_BITS-1:0]  araddr;
  logic [AXI_LEN_BITS-1:0]   arlen;
  logic [AXI_SIZE_BITS-1:0]  arsize;
  logic [AXI_BURST_BITS-1:0] arburst;
  logic                      arvalid;
  logic                      arready;
  // Read data channel
  logic [AXI_ID_BITS-1:0]    rid;
  logic [AXI_DATA_BITS-1:0]  rdata;
  logic [AXI_RESP_BITS-1:0]  rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport M2AXIout (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready
  );

  modport M2AXIin (
    input awready, wready,
    input bid, bresp, bvalid,
    input arready,
    input rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_burst_master_ctrl.sv
// ---------------------------------------------------------------------------
// axi_burst_master_ctrl
//   Turns a one-shot command (address, length, direction) from a single
//   requester into a complete AXI4 read (AR/R) or write (AW/W/B) burst and
//   streams beat data between the requester and the master port.
//   Ports:
//     ACLK, ARESETn          clock, asynchronous active-low reset
//     req_*                  command handshake (addr, len = beats-1, write)
//     wr_data/strb/valid     write beats from the requester, wr_ready back
//     rd_data/valid/last     read beats to the requester, rd_ready back
//     done, err              one-cycle completion pulse and its error flag
//     m_in / m_out           slave-to-master / master-to-slave AXI signals
//   Beat data passes through combinationally in both directions; every
//   channel output is forced to zero outside the state that owns it.
// ---------------------------------------------------------------------------
module axi_burst_master_ctrl
  import axi_master_ctrl_pkg::*;
#(
  parameter logic [AXI_ID_BITS-1:0]   MASTER_ID  = 4'd0,
  parameter logic [AXI_SIZE_BITS-1:0] BURST_SIZE = 3'b010
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [AXI_ADDR_BITS-1:0] req_addr,
  input  logic [AXI_LEN_BITS-1:0]  req_len,
  input  logic [AXI_DATA_BITS-1:0] wr_data,
  input  logic [AXI_STRB_BITS-1:0] wr_strb,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [AXI_DATA_BITS-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  input  logic                     rd_ready,
  output logic                     done,
  output logic                     err,
  inf_Master.M2AXIin               m_in,
  inf_Master.M2AXIout              m_out
);

  ctrl_state_t              state_q, state_d;
  logic [AXI_ADDR_BITS-1:0] addr_q, addr_d;
  logic [AXI_LEN_BITS-1:0]  len_q, len_d;
  logic [AXI_LEN_BITS-1:0]  cnt_q, cnt_d;      // beats already transferred
  logic                     err_q, err_d;      // sticky error for this burst
  logic                     done_q, done_d;
  logic                     done_err_q, done_err_d;

  logic in_ar, in_r, in_aw, in_w, in_b;
  logic r_hs, w_hs;
  logic at_last;
  logic r_beat_err;

  assign in_ar = (state_q == ST_AR);
  assign in_r  = (state_q == ST_R);
  assign in_aw = (state_q == ST_AW);
  assign in_w  = (state_q == ST_W);
  assign in_b  = (state_q == ST_B);

  assign r_hs    = in_r && m_in.rvalid && rd_ready;
  assign w_hs    = in_w && wr_valid && m_in.wready;
  assign at_last = (cnt_q == len_q);

  // A read beat is in error on a bad response, when rlast arrives early or
  // late, or when the expected last beat arrives without rlast (the burst is
  // still drained until the slave finally raises rlast).
  assign r_beat_err = (m_in.rresp != RESP_OKAY) || (m_in.rlast ? !at_last : at_last);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          len_d   = req_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = req_write ? ST_AW : ST_AR;
        end
      end

      ST_AR: begin
        if (m_in.arready) state_d = ST_R;
      end

      ST_R: begin
        if (r_hs) begin
          cnt_d = sat_inc(cnt_q);
          err_d = err_q | r_beat_err;
          if (m_in.rlast) begin
            done_d     = 1'b1;
            done_err_d = err_q | r_beat_err;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_AW: begin
        if (m_in.awready) state_d = ST_W;
      end

      ST_W: begin
        if (w_hs) begin
          cnt_d = sat_inc(cnt_q);
          if (at_last) state_d = ST_B;
        end
      end

      ST_B: begin
        if (m_in.bvalid) begin
          done_d     = 1'b1;
          done_err_d = err_q | (m_in.bresp != RESP_OKAY);
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  // Requester side
  assign req_ready = (state_q == ST_IDLE);
  assign wr_ready  = in_w & m_in.wready;
  assign rd_valid  = in_r & m_in.rvalid;
  assign rd_last   = in_r & m_in.rlast;
  assign rd_data   = in_r ? m_in.rdata : '0;
  assign done      = done_q;
  assign err       = done_err_q;

  // Read address channel
  assign m_out.arvalid = in_ar;
  assign m_out.araddr  = in_ar ? addr_q     : '0;
  assign m_out.arlen   = in_ar ? len_q      : '0;
  assign m_out.arsize  = in_ar ? BURST_SIZE : '0;
  assign m_out.arburst = in_ar ? BURST_INCR : '0;
  assign m_out.arid    = in_ar ? MASTER_ID  : '0;

  // Read data channel
  assign m_out.rready  = in_r & rd_ready;

  // Write address channel
  assign m_out.awvalid = in_aw;
  assign m_out.awaddr  = in_aw ? addr_q     : '0;
  assign m_out.awlen   = in_aw ? len_q      : '0;
  assign m_out.awsize  = in_aw ? BURST_SIZE : '0;
  assign m_out.awburst = in_aw ? BURST_INCR : '0;
  assign m_out.awid    = in_aw ? MASTER_ID  : '0;

  // Write data channel
  assign m_out.wvalid  = in_w & wr_valid;
  assign m_out.wdata   = in_w ? wr_data : '0;
  assign m_out.wstrb   = in_w ? wr_strb : '0;
  assign m_out.wlast   = in_w & at_last;

  // Write response channel
  assign m_out.bready  = in_b;

  // This block is the only user of the port, so response IDs carry no
  // information and are deliberately dropped.
  logic unused_ids;
  assign unused_ids = ^{m_in.bid, m_in.rid};

endmodule

// File: tb/tb_axi_burst_master_ctrl.sv
module tb_axi_burst_master_ctrl;

  logic        ACLK;
  logic        ARESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        rd_ready;
  logic        done;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  inf_Master axi();

  axi_burst_master_ctrl dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .rd_ready  (rd_ready),
    .done      (done),
    .err       (err),
    .m_in      (axi),
    .m_out     (axi)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {31'd0, |{axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awvalid,
                       axi.wdata, axi.wstrb, axi.wlast, axi.wvalid, axi.bready,
                       axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arvalid,
                       axi.rready, rd_valid, rd_last, rd_data, wr_ready, done, err}}, 32'd0);
  endtask

  task automatic issue_req(input bit wr, input logic [31:0] addr, input logic [3:0] len);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    #1;
    chk("req_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
  endtask

  // Address phase with the slave's ready delayed by 'delay' cycles. The
  // requester offers write data meanwhile; it must not reach the W channel.
  task automatic addr_phase(input bit wr, input logic [31:0] addr, input logic [3:0] len, input int delay);
    for (int d = 0; d <= delay; d++) begin
      if (wr) axi.awready = (d == delay);
      else    axi.arready = (d == delay);
      wr_valid   = 1'b1;
      axi.wready = 1'b1;
      #1;
      chk("avalid",       wr ? axi.awvalid : axi.arvalid, 1);
      chk("aaddr",        wr ? axi.awaddr  : axi.araddr,  addr);
      chk("alen",         wr ? axi.awlen   : axi.arlen,   len);
      chk("aburst",       wr ? axi.awburst : axi.arburst, 32'h1);
      chk("asize",        wr ? axi.awsize  : axi.arsize,  32'h2);
      chk("aid",          wr ? axi.awid    : axi.arid,    0);
      chk("other_avalid", wr ? axi.arvalid : axi.awvalid, 0);
      chk("wvalid_gated", axi.wvalid, 0);
      chk("wr_ready_gated", wr_ready, 0);
      chk("req_ready_busy", req_ready, 0);
      chk("done_low", done, 0);
      step();
    end
    axi.arready = 1'b0;
    axi.awready = 1'b0;
    wr_valid    = 1'b0;
    axi.wready  = 1'b0;
  endtask

  // Read burst: the slave sends 'nbeats' beats with rlast on the final one,
  // SLVERR on beat 'bad_idx' (negative = none), and the requester drops
  // rd_ready for 'stall_len' cycles starting at R-phase cycle 'stall_start'.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input int nbeats,
                         input int bad_idx, input int ar_delay, input int stall_start,
                         input int stall_len, input bit gaps);
    logic [31:0] data_q[$];
    logic [1:0]  resp_q[$];
    bit          exp_err;
    bit          pres;
    int          idx;
    int          cyc;
    for (int i = 0; i < nbeats; i++) begin
      data_q.push_back($urandom);
      resp_q.push_back((i == bad_idx) ? 2'b10 : 2'b00);
    end
    exp_err = (nbeats != int'(len) + 1) || (bad_idx >= 0 && bad_idx < nbeats);

    issue_req(1'b0, addr, len);
    addr_phase(1'b0, addr, len, ar_delay);

    idx  = 0;
    cyc  = 0;
    pres = 1'b0;
    while (idx < nbeats && cyc < 400) begin
      if (!pres) pres = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      rd_ready   = !(cyc >= stall_start && cyc < stall_start + stall_len);
      axi.rvalid = pres;
      axi.rdata  = data_q[idx];
      axi.rresp  = resp_q[idx];
      axi.rlast  = (idx == nbeats - 1);
      #1;
      chk("rready", axi.rready, rd_ready);
      chk("rd_valid", rd_valid, pres);
      chk("rd_data", rd_data, data_q[idx]);
      chk("rd_last", rd_last, (idx == nbeats - 1));
      chk("done_low_r", done, 0);
      if (pres && rd_ready) begin
        idx++;
        pres = 1'b0;
      end
      step();
      cyc++;
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rdata  = '0;
    axi.rresp  = '0;
    rd_ready   = 1'b0;
    #1;
    chk("r_beats", idx, nbeats);
    chk("r_done", done, 1);
    chk("r_err", err, exp_err);
    chk("req_ready_done", req_ready, 1);
    $display("read  addr=%08h len=%0d beats=%0d err=%0b exp_err=%0b", addr, len, idx, err, exp_err);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] bresp,
                          input int aw_delay, input int b_delay, input bit toggle);
    logic [31:0] data_q[$];
    logic [3:0]  strb_q[$];
    int          idx;
    int          cyc;
    bit          exp_err;
    for (int i = 0; i <= int'(len); i++) begin
      data_q.push_back($urandom);
      strb_q.push_back(4'($urandom_range(0, 15)));
    end
    exp_err = (bresp != 2'b00);

    issue_req(1'b1, addr, len);
    addr_phase(1'b1, addr, len, aw_delay);

    idx = 0;
    cyc = 0;
    while (idx <= int'(len) && cyc < 400) begin
      wr_valid   = ($urandom_range(0, 2) != 0);
      axi.wready = toggle ? (cyc % 2 == 1) : ($urandom_range(0, 1) == 1);
      wr_data    = data_q[idx];
      wr_strb    = strb_q[idx];
      #1;
      chk("wvalid", axi.wvalid, wr_valid);
      chk("wdata", axi.wdata, data_q[idx]);
      chk("wstrb", axi.wstrb, strb_q[idx]);
      chk("wr_ready", wr_ready, axi.wready);
      chk("wlast", axi.wlast, (idx == int'(len)));
      chk("bready_in_w", axi.bready, 0);
      if (wr_valid && axi.wready) idx++;
      step();
      cyc++;
    end
    chk("w_beats", idx, int'(len) + 1);

    for (int d = 0; d <= b_delay; d++) begin
      wr_valid   = 1'b1;
      axi.wready = 1'b1;
      axi.bvalid = (d == b_delay);
      axi.bresp  = bresp;
      #1;
      chk("bready", axi.bready, 1);
      chk("wvalid_in_b", axi.wvalid, 0);
      chk("wr_ready_in_b", wr_ready, 0);
      chk("done_low_b", done, 0);
      step();
    end
    axi.bvalid = 1'b0;
    axi.bresp  = '0;
    wr_valid   = 1'b0;
    axi.wready = 1'b0;
    #1;
    chk("b_done", done, 1);
    chk("b_err", err, exp_err);
    chk("req_ready_done", req_ready, 1);
    $display("write addr=%08h len=%0d beats=%0d bresp=%0d err=%0b exp_err=%0b",
             addr, len, idx, bresp, err, exp_err);
  endtask

  task automatic reset_in_w();
    issue_req(1'b1, 32'h0000_2000, 4'd3);
    addr_phase(1'b1, 32'h0000_2000, 4'd3, 0);
    for (int i = 0; i < 2; i++) begin
      wr_valid   = 1'b1;
      axi.wready = 1'b1;
      wr_data    = $urandom;
      #1;
      chk("wvalid_pre_rst", axi.wvalid, 1);
      chk("wlast_pre_rst", axi.wlast, 0);
      step();
    end
    wr_valid   = 1'b1;
    axi.wready = 1'b1;
    axi.bvalid = 1'b1;
    axi.rvalid = 1'b1;
    rd_ready   = 1'b1;
    ARESETn    = 1'b0;
    #1;
    chk_idle("rst_mid_w");
    step();
    chk_idle("rst_held");
    ARESETn    = 1'b1;
    wr_valid   = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    axi.rvalid = 1'b0;
    rd_ready   = 1'b0;
    step();
    chk("req_ready_after_rst", req_ready, 1);
    chk_idle("idle_after_rst");
    $display("reset asserted in W state, block back to idle");
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  l;
    int          nb;
    int          bad;

    ARESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_data   = '0;
    wr_strb   = '0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bid     = '0;
    axi.bresp   = '0;
    axi.bvalid  = 1'b0;
    axi.arready = 1'b0;
    axi.rid     = '0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;

    #2;
    chk_idle("reset_outputs");
    chk("reset_req_ready", req_ready, 1);
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    step();
    chk_idle("post_reset_outputs");

    // Plain 4-beat read with arready delayed two cycles.
    do_read(32'h0000_1000, 4'd3, 4, -1, 2, 100, 0, 1'b0);
    // Two-beat write, gapped requester data, toggling wready.
    do_write(32'h0000_4000, 4'd1, 2'b00, 0, 1, 1'b1);
    // Requester stalls five cycles mid-burst.
    do_read(32'h0000_8000, 4'd5, 6, -1, 0, 2, 5, 1'b0);
    // Early rlast on beat 2, next command accepted in the done cycle.
    do_read(32'h0000_1000, 4'd3, 2, -1, 0, 100, 0, 1'b0);
    do_read(32'h0000_1100, 4'd0, 1, -1, 1, 100, 0, 1'b0);
    // Length reached without rlast: drained until rlast, flagged.
    do_read(32'h0000_1200, 4'd1, 3, -1, 0, 100, 0, 1'b0);
    // SLVERR write response, then a clean read.
    do_write(32'h0000_5000, 4'd2, 2'b10, 1, 2, 1'b0);
    do_read(32'h0000_6000, 4'd2, 3, -1, 0, 100, 0, 1'b1);
    // Maximum length burst with SLVERR on one beat.
    do_read(32'h0000_7000, 4'd15, 16, 7, 0, 100, 0, 1'b0);
    // Reset during the W phase, then a fresh read.
    reset_in_w();
    do_read(32'h0000_9000, 4'd3, 4, -1, 0, 100, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      a      = $urandom;
      a[1:0] = 2'b00;
      l      = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, l, ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end else begin
        nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : int'(l) + 1;
        bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1;
        do_read(a, l, nb, bad, $urandom_range(0, 3), $urandom_range(0, 5),
                $urandom_range(0, 3), 1'b1);
      end
    end

    step();
    chk("final_done_low", done, 0);
    chk("final_req_ready", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
